cache_instruction: RTL and testbench
====================================

Name: cache_instruction

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch path (10-bit byte address from PC[9:0]) and a 1 KB instruction memory.
- The instruction memory has a 128-bit (16-byte) block interface.
- On a hit, it returns the 32-bit instruction combinationally.
- On a miss, it stalls the CPU via busywait, fetches the whole block, installs it, then serves the hit.

Parameters:
- None. Geometry is fixed by localparams:
  - 8 blocks.
  - 16 bytes per block (4 words).
  - Tag 3 bits, index 3 bits, word offset 2 bits, byte offset 2 bits (ignored).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- address  input  10  instruction byte address. [9:7]=tag, [6:4]=index, [3:2]=word offset, [1:0] ignored (word-aligned).
- mem_busywait  input  1  instruction memory busy; high while a block read is in progress.
- mem_readdata  input  128  block from memory. Word n occupies bits [32n+31:32n].
- mem_address  output  6  block address to memory, = {tag, index}.
- readdata  output  32  instruction word to the CPU.
- busywait  output  1  stall request to the CPU; ORed externally with the data-cache stall.
- mem_read  output  1  block read request to the instruction memory.

Behaviour:
- Storage, per line:
  - valid bit
  - 3-bit tag
  - 128-bit data block
- Lookup (combinational):
  - hit = valid[index] && (tag_array[index] == address[9:7]).
  - readdata = data_array[index] word selected by address[3:2]. It is driven whenever hit; otherwise it holds the selected word with don't-care content.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - mem_read=0.
  - busywait = !hit (combinational, same cycle the address changes).
  - On hit: stay in IDLE.
  - On miss: next state MEM_READ.
- MEM_READ:
  - mem_read=1, mem_address={address[9:7], address[6:4]}, busywait=1.
  - Memory raises mem_busywait in response and drops it when mem_readdata is valid.
  - On the first edge with mem_busywait=0: next state UPDATE.
- UPDATE:
  - mem_read=0, busywait=1.
  - At the edge: data_array[index] <= mem_readdata, tag_array[index] <= address[9:7], valid[index] <= 1, next state IDLE.
  - The following cycle hits; busywait drops combinationally.
- Address stability: the CPU holds address constant while busywait=1. The cache latches nothing else.
- Miss penalty: 1 cycle (IDLE→MEM_READ) + memory latency + 1 UPDATE cycle.
- Reset (synchronous, at the rising edge with RESET=1), with priority over every other event:
  - All valid bits cleared.
  - FSM forced to IDLE.
  - mem_read=0.
  - Tag/data arrays need not be cleared.
- Reset mid-fill: an abandoned fill leaves the line invalid. Memory completes or aborts on its own; the cache ignores its data.
- After reset the first fetch always misses. busywait is then asserted combinationally from IDLE, so it reads 1 whenever the first post-reset address is presented.
- Conflict: a miss to an index with a valid line of another tag overwrites the line. There is no write-back (read-only).
- mem_readdata is sampled only in the UPDATE transition and ignored in every other state.

Decomposition:
- Shared package cache_pkg holds:
  - TAG_W=3, IDX_W=3, OFF_W=2, BLOCK_W=128, NUM_LINES=8
  - enum state_t {IDLE, MEM_READ, UPDATE}
- The data cache uses the same package.
- One natural sub-module: cache_line_store, holding the valid/tag/data arrays with one write port and one combinational read port. The FSM and hit logic stay in the top.

Test Plan:
- Cold miss:
  - Stimulus: RESET for 1 edge, then address=0x000. Memory returns block 0x0000000D_0000000C_0000000B_0000000A after 5 busy cycles.
  - Required: busywait=1 immediately; mem_read=1 with mem_address=0 on the next cycle.
  - Required: busywait falls the cycle after UPDATE, with readdata=0x0000000A.
- Same-block hits:
  - Stimulus: after the fill, step address 0x004, 0x008, 0x00C.
  - Required: busywait stays 0 and mem_read stays 0; readdata = 0x0B, 0x0C, 0x0D.
- Byte-offset ignore:
  - Stimulus: address=0x006.
  - Required: readdata=0x0000000B, hit.
- Conflict eviction:
  - Stimulus: address=0x080 (tag 1, index 0).
  - Required: miss, mem_address=6'b001000, new block installed.
  - Required: a return to 0x000 misses again.
- Reset invalidation:
  - Stimulus: fill index 2 (address 0x020), assert RESET for 1 edge, re-present 0x020.
  - Required: miss, mem_read reasserted.
- Reset mid-fill:
  - Stimulus: assert RESET during MEM_READ.
  - Required: next cycle mem_read=0, FSM in IDLE, line still invalid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and helpers for the instruction and data caches.
// A 10-bit byte address splits into tag[9:7], index[6:4], word[3:2] and byte[1:0].
package cache_pkg;

    localparam int TAG_W     = 3;
    localparam int IDX_W     = 3;
    localparam int OFF_W     = 2;
    localparam int BLOCK_W   = 128;
    localparam int NUM_LINES = 8;
    localparam int WORD_W    = 32;
    localparam int ADDR_W    = TAG_W + IDX_W + OFF_W + 2;
    localparam int BADDR_W   = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    // Word n of a block sits at bits [32n+31:32n].
    function automatic logic [WORD_W-1:0] select_word(
        input logic [BLOCK_W-1:0] block,
        input logic [OFF_W-1:0]   offset
    );
        logic [6:0] base;
        base = {offset, 5'b00000};
        return block[base +: WORD_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-TAG_W-1 -: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for a direct-mapped cache: one write port used to
// install a fetched block, one combinational read port used by the hit check.
// Only the valid bits are reset; tag and data contents are meaningless while
// their valid bit is clear.
module cache_line_store
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_array  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_array [NUM_LINES];

    // Valid bits: cleared by reset (which wins over a fill in the same edge), set when a line is installed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays: written on install only, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_array[wr_index]  <= wr_tag;
            data_array[wr_index] <= wr_data;
        end
    end

    // Combinational read port for the lookup.
    always_comb begin
        rd_valid = valid[rd_index];
        rd_tag   = tag_array[rd_index];
        rd_data  = data_array[rd_index];
    end

endmodule

// File: rtl/cache_instruction.sv
// Direct-mapped, read-only instruction cache: 8 lines of 16 bytes in front of
// a 1 KB instruction memory with a 128-bit block interface. Hits return the
// instruction combinationally; a miss stalls the CPU, fetches the block,
// installs it and then serves the hit from the refilled line.
module cache_instruction
    import cache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   address,
    input  logic                mem_busywait,
    input  logic [BLOCK_W-1:0]  mem_readdata,
    output logic [BADDR_W-1:0]  mem_address,
    output logic [WORD_W-1:0]   readdata,
    output logic                busywait,
    output logic                mem_read
);

    state_t              state;

    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    index;
    logic [OFF_W-1:0]    offset;

    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic [BLOCK_W-1:0]  line_data;
    logic                hit;
    logic                fill_en;

    // Byte offset bits carry no information for word-aligned fetches.
    logic                byte_offset_unused;

    // Address field split; the CPU holds the address stable during a stall,
    // so the fill uses these fields directly without latching them.
    always_comb begin
        tag                = addr_tag(address);
        index              = addr_index(address);
        offset             = addr_offset(address);
        byte_offset_unused = ^address[1:0];
    end

    cache_line_store u_line_store (
        .clk      (CLK),
        .rst      (RESET),
        .wr_en    (fill_en),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_data  (mem_readdata),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    // Hit detection, word select and stall request. In IDLE the stall follows
    // the hit check in the same cycle the address changes; any fill state stalls.
    always_comb begin
        hit         = line_valid && (line_tag == tag);
        readdata    = select_word(line_data, offset);
        busywait    = (state != IDLE) || !hit;
        mem_address = {tag, index};
        fill_en     = (state == UPDATE);
    end

    // Miss-handling FSM with a registered memory read request; reset has
    // priority and abandons any fill in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            mem_read <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        state    <= MEM_READ;
                        mem_read <= 1'b1;
                    end
                end
                MEM_READ: begin
                    // Memory drops its busy flag once the block is valid.
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    // The line store captures mem_readdata at this edge.
                    state    <= IDLE;
                    mem_read <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_instruction.sv
// Self-checking bench for cache_instruction: a behavioural instruction memory
// with variable latency plus a reference model of which blocks are resident.
module tb_cache_instruction;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [9:0]   address;
    logic         mem_busywait;
    logic [127:0] mem_readdata;
    logic [5:0]   mem_address;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;

    always #5 CLK = ~CLK;

    cache_instruction dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .address      (address),
        .mem_busywait (mem_busywait),
        .mem_readdata (mem_readdata),
        .mem_address  (mem_address),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Memory contents, 64 blocks of 16 bytes.
    logic [127:0] mem_blk [64];
    int           mem_lat = 5;

    // Reference model: which block (tag) each line holds.
    bit           ref_valid [8];
    logic [2:0]   ref_tag   [8];

    // Behavioural memory: raises busy right after a request, returns the block
    // after mem_lat cycles, aborts if the request vanishes.
    logic [5:0] req_addr;
    bit         aborted;
    initial begin
        mem_busywait = 1'b0;
        mem_readdata = '0;
        forever begin
            @(posedge CLK); #1;
            if (mem_read) begin
                req_addr     = mem_address;
                mem_busywait = 1'b1;
                mem_readdata = {$urandom, $urandom, $urandom, $urandom};
                aborted      = 1'b0;
                for (int i = 0; i < mem_lat && !aborted; i++) begin
                    @(posedge CLK); #1;
                    if (!mem_read) aborted = 1'b1;
                end
                if (!aborted) mem_readdata = mem_blk[req_addr];
                mem_busywait = 1'b0;
            end
        end
    end

    function automatic logic [31:0] word_of(input logic [127:0] blk, input int w);
        return 32'(blk >> (32 * w));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    // Present an address (called #1 after a rising edge) and check the whole
    // hit or miss sequence; returns #1 after the edge following completion.
    task automatic fetch(input logic [9:0] a);
        logic [2:0] t;
        logic [2:0] idx;
        int         w;
        bit         hit;
        t   = a[9:7];
        idx = a[6:4];
        w   = int'(a[3:2]);
        address = a;
        hit = ref_valid[idx] && (ref_tag[idx] == t);
        @(negedge CLK);
        check("busy_now", busywait, !hit);
        check("rd_idle", mem_read, 1'b0);
        if (hit) begin
            check("hit_data", readdata, word_of(mem_blk[a[9:4]], w));
        end else begin
            for (int k = 1; k <= mem_lat + 3; k++) begin
                @(negedge CLK);
                if (k <= mem_lat + 1) begin
                    check("rd_fill", mem_read, 1'b1);
                    check("mem_addr", mem_address, a[9:4]);
                end else begin
                    check("rd_off", mem_read, 1'b0);
                end
                check("busy_fill", busywait, (k < mem_lat + 3));
            end
            check("fill_data", readdata, word_of(mem_blk[a[9:4]], w));
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = t;
        end
        @(posedge CLK); #1;
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        clear_model();
    endtask

    logic [9:0] ra;

    initial begin
        for (int i = 0; i < 64; i++) mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_blk[0] = 128'h0000000D_0000000C_0000000B_0000000A;
        clear_model();
        RESET   = 1'b1;
        address = 10'h000;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Cold miss on 0x000 with 5 busy cycles, then same-block hits.
        mem_lat = 5;
        fetch(10'h000);
        check("cold_word0", readdata, 32'h0000000A);
        fetch(10'h004);
        fetch(10'h008);
        fetch(10'h00C);
        fetch(10'h006);
        address = 10'h006;
        @(negedge CLK);
        check("byte_ign_data", readdata, 32'h0000000B);
        check("byte_ign_hit", busywait, 1'b0);
        @(posedge CLK); #1;

        // Conflict eviction: tag 1 index 0 replaces tag 0, then 0x000 misses again.
        mem_lat = 3;
        fetch(10'h080);
        fetch(10'h000);
        check("reload_word0", readdata, 32'h0000000A);

        // Reset invalidates a filled line.
        mem_lat = 2;
        fetch(10'h020);
        fetch(10'h024);
        pulse_reset();
        fetch(10'h020);

        // Reset while the fill is in flight: the line stays invalid and the
        // cache restarts from IDLE with the same address.
        mem_lat = 4;
        address = 10'h150;
        @(posedge CLK);
        @(negedge CLK);
        check("midfill_rd", mem_read, 1'b1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        clear_model();
        fetch(10'h150);
        fetch(10'h154);

        // Randomised traffic over a small working set with occasional resets.
        for (int n = 0; n < 80; n++) begin
            ra      = {2'b00, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) ra[9:8] = 2'($urandom_range(0, 3));
            mem_lat = $urandom_range(1, 6);
            if ($urandom_range(0, 15) == 0) pulse_reset();
            fetch(ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
